// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ASR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

  // EXEC is the one cycle in which a single-cycle op is evaluated from the captured operands.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                            input logic z, input logic n);
    logic [3:0] f;
    f        = '0;
    f[FLG_C] = c;
    f[FLG_V] = v;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles.
module alu_mul_iter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_cnt;
  logic               r_busy;
  logic               r_done;

  // Iteration control; done is a one-cycle pulse after the last partial product is added.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end else if (r_busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == SHW'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  // Shift-add datapath: accumulate the shifted multiplicand when the current multiplier bit is set.
  always_ff @(posedge clk) begin
    if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign done = r_done;
  assign prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake, iterative multiply and a registered C/V/Z/N flag file.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  // Shift amounts above WIDTH+1 behave like WIDTH+1: everything shifted out, last bit out is fill.
  localparam logic [WIDTH-1:0] AMT_LIM = WIDTH'(WIDTH + 1);
  localparam logic [SHW:0]     AMT_MAX = (SHW + 1)'(WIDTH + 1);

  state_t             r_state;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_res_hi;
  logic [3:0]         r_flags;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [3:0]         w_mul_flags;

  logic               w_is_sub;
  logic [WIDTH-1:0]   w_bop;
  logic [WIDTH:0]     w_sum;
  logic               w_add_v;
  logic [SHW:0]       w_amt;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic signed [WIDTH:0] w_asr;

  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_zn;
  logic               w_c;
  logic               w_v;
  logic [3:0]         w_flags;

  assign w_accept    = (r_state == ST_IDLE) && in_valid;
  assign w_mul_start = w_accept && (op == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_mul_start),
    .a     (a),
    .b     (b),
    .done  (w_mul_done),
    .prod  (w_prod)
  );

  assign w_mul_flags = pack_flags(|w_prod[2*WIDTH-1:WIDTH], 1'b0,
                                  (w_prod[WIDTH-1:0] == '0), w_prod[WIDTH-1]);

  // Adder shared by ADD/SUB/CMP; subtraction is a + ~b + cin.
  assign w_is_sub = (r_op == OP_SUB) || (r_op == OP_CMP);
  assign w_bop    = w_is_sub ? ~r_b : r_b;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, r_cin};
  assign w_add_v  = (r_a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  // Shifters carry one extra bit so the last bit shifted out falls out as the carry.
  assign w_amt = (r_b > AMT_LIM) ? AMT_MAX : r_b[SHW:0];
  assign w_shl = {1'b0, r_a} << w_amt;
  assign w_shr = {r_a, 1'b0} >> w_amt;
  assign w_asr = $signed({r_a, 1'b0}) >>> w_amt;

  // Single-cycle result and flag selection from the captured operands.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
      end
      OP_CMP: begin
        w_c = w_sum[WIDTH];
        w_v = w_add_v;
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOT: w_res = ~r_a;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_ASR: begin
        w_res = w_asr[WIDTH:1];
        w_c   = w_asr[0];
      end
      default: begin
        w_res = '0;
      end
    endcase
    w_zn    = (r_op == OP_CMP) ? w_sum[WIDTH-1:0] : w_res;
    w_flags = pack_flags(w_c, w_v, (w_zn == '0), w_zn[WIDTH-1]);
  end

  // Control FSM and flag file; flags only move on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) r_state <= (op == OP_MUL) ? ST_MUL : ST_EXEC;
        end
        ST_EXEC: begin
          r_state <= ST_DONE;
          r_flags <= w_flags;
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_state <= ST_DONE;
            r_flags <= w_mul_flags;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand capture at acceptance and result latch on completion; held while DONE waits.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op  <= op;
      r_a   <= a;
      r_b   <= b;
      r_cin <= use_carry ? r_flags[FLG_C] : ((op == OP_SUB) || (op == OP_CMP));
    end
    if (r_state == ST_EXEC) begin
      r_res    <= w_res;
      r_res_hi <= '0;
    end
    if ((r_state == ST_MUL) && w_mul_done) begin
      r_res    <= w_prod[WIDTH-1:0];
      r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = out_valid ? r_res : '0;
  assign result_hi = out_valid ? r_res_hi : '0;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16, sharing one stimulus path.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        use_carry;
  logic        sel16;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;

  logic        iv8, iv16;
  logic        in_ready8, out_valid8, in_ready16, out_valid16;
  logic [7:0]  res8, hi8;
  logic [15:0] res16, hi16;
  logic [3:0]  flg8, flg16;

  logic        in_ready, out_valid;
  logic [15:0] result, result_hi;
  logic [3:0]  flags;

  int n_cmp;
  int n_mis;

  always #5 clk = ~clk;

  assign iv8  = in_valid & ~sel16;
  assign iv16 = in_valid & sel16;

  alu_seq #(.WIDTH(8), .SHW(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(in_ready8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .use_carry(use_carry), .out_valid(out_valid8),
    .out_ready(out_ready & ~sel16), .result(res8), .result_hi(hi8), .flags(flg8)
  );

  alu_seq #(.WIDTH(16), .SHW(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(in_ready16), .op(op),
    .a(a), .b(b), .use_carry(use_carry), .out_valid(out_valid16),
    .out_ready(out_ready & sel16), .result(res16), .result_hi(hi16), .flags(flg16)
  );

  assign in_ready  = sel16 ? in_ready16  : in_ready8;
  assign out_valid = sel16 ? out_valid16 : out_valid8;
  assign result    = sel16 ? res16 : {8'h00, res8};
  assign result_hi = sel16 ? hi16  : {8'h00, hi8};
  assign flags     = sel16 ? flg16 : flg8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: accept, scramble inputs, wait for out_valid, check, optionally hold, consume.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] ia,
                        input logic [15:0] ib, input logic uc, input int lat_exp,
                        input logic [15:0] er, input logic [15:0] eh, input logic [3:0] ef,
                        input int hold, input bit poke);
    int lat;
    @(negedge clk);
    chk({tag, ".rdy"}, in_ready, 1);
    op = o; a = ia; b = ib; use_carry = uc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ia; b = ~ib; op = OP_ADD; use_carry = ~uc;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 3) begin
        chk({tag, ".busy"}, in_ready, 0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end while (!out_valid && lat < 64);
    in_valid = 1'b0;
    chk({tag, ".lat"}, lat, lat_exp);
    chk({tag, ".res"}, result, er);
    chk({tag, ".hi"}, result_hi, eh);
    chk({tag, ".flg"}, flags, ef);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_ov"}, out_valid, 1);
      chk({tag, ".hold_res"}, result, er);
      chk({tag, ".hold_flg"}, flags, ef);
    end
    // A request offered on the edge that leaves DONE must not be taken.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk({tag, ".ov_clr"}, out_valid, 0);
    chk({tag, ".res_clr"}, result, 0);
    chk({tag, ".idle"}, in_ready, 1);
    chk({tag, ".flg_keep"}, flags, ef);
  endtask

  task automatic suite(input bit w);
    logic [15:0] m;
    int          l;
    int          seen;
    string       p;
    m = w ? 16'hFFFF : 16'h00FF;
    l = w ? 17 : 9;
    p = w ? "w16" : "w8";

    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({p, ".rst_rdy"}, in_ready, 1);
    chk({p, ".rst_ov"}, out_valid, 0);
    chk({p, ".rst_res"}, result, 0);
    chk({p, ".rst_hi"}, result_hi, 0);
    chk({p, ".rst_flg"}, flags, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    run_op({p, ".add"},  OP_ADD, w ? 16'h7FFF : 16'h007F, 16'h0001, 1'b0, 1,
           w ? 16'h8000 : 16'h0080, 16'h0, 4'b0101, 0, 1'b0);
    run_op({p, ".sbc"},  OP_SUB, 16'h0000, 16'h0001, 1'b1, 1, m & 16'hFFFE, 16'h0, 4'b0001, 0, 1'b0);
    run_op({p, ".cmp"},  OP_CMP, 16'h0005, 16'h0005, 1'b0, 1, 16'h0000, 16'h0, 4'b1010, 0, 1'b0);
    run_op({p, ".adc"},  OP_ADD, 16'h0001, 16'h0001, 1'b1, 1, 16'h0003, 16'h0, 4'b0000, 0, 1'b0);
    run_op({p, ".and"},  OP_AND, w ? 16'hF0F0 : 16'h00F0, w ? 16'h0F0F : 16'h000F, 1'b0, 1,
           16'h0000, 16'h0, 4'b0010, 0, 1'b0);
    run_op({p, ".or"},   OP_OR,  16'h0030, 16'h0003, 1'b0, 1, 16'h0033, 16'h0, 4'b0000, 0, 1'b0);
    run_op({p, ".xor"},  OP_XOR, 16'h003C, 16'h000F, 1'b0, 1, 16'h0033, 16'h0, 4'b0000, 0, 1'b0);
    run_op({p, ".not"},  OP_NOT, 16'h000F, 16'h0000, 1'b0, 1, m & 16'hFFF0, 16'h0, 4'b0001, 0, 1'b0);
    run_op({p, ".shl"},  OP_SHL, w ? 16'h8001 : 16'h0081, 16'h0001, 1'b0, 1, 16'h0002, 16'h0, 4'b1000, 0, 1'b0);
    run_op({p, ".asr"},  OP_ASR, w ? 16'h9000 : 16'h0090, 16'h0002, 1'b0, 1,
           w ? 16'hE400 : 16'h00E4, 16'h0, 4'b0001, 0, 1'b0);
    run_op({p, ".shr"},  OP_SHR, m, w ? 16'd17 : 16'd9, 1'b0, 1, 16'h0000, 16'h0, 4'b0010, 0, 1'b0);
    run_op({p, ".asr2"}, OP_ASR, w ? 16'h8000 : 16'h0080, w ? 16'd20 : 16'd12, 1'b0, 1,
           m, 16'h0, 4'b1001, 0, 1'b0);
    run_op({p, ".undef"}, 4'hF, 16'h0005, 16'h0003, 1'b0, 1, 16'h0000, 16'h0, 4'b0010, 0, 1'b0);
    run_op({p, ".mul"},  OP_MUL, m, m, 1'b0, l, 16'h0001, m & 16'hFFFE, 4'b1000, 0, 1'b1);
    run_op({p, ".mul2"}, OP_MUL, 16'h000C, 16'h000A, 1'b0, l, 16'h0078, 16'h0000, 4'b0000, 0, 1'b0);
    run_op({p, ".bp"},   OP_ADD, w ? 16'h7FFF : 16'h007F, 16'h0001, 1'b0, 1,
           w ? 16'h8000 : 16'h0080, 16'h0, 4'b0101, 5, 1'b0);

    // Abort a multiply with a reset pulse in its fourth iteration.
    @(negedge clk);
    op = OP_MUL; a = 16'h0003; b = 16'h0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk({p, ".ab_busy"}, in_ready, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk({p, ".ab_rdy"}, in_ready, 1);
    chk({p, ".ab_ov"}, out_valid, 0);
    chk({p, ".ab_flg"}, flags, 4'b0000);
    chk({p, ".ab_res"}, result, 0);
    seen = 0;
    repeat (l + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk({p, ".ab_none"}, seen, 0);

    run_op({p, ".post"}, OP_ADD, 16'h0002, 16'h0003, 1'b0, 1, 16'h0005, 16'h0, 4'b0000, 0, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; use_carry = 1'b0;
    op = 4'h0; a = 16'h0; b = 16'h0; sel16 = 1'b0;
    suite(1'b0);
    sel16 = 1'b1;
    suite(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
